// File: rtl/dispatch_alloc_unit.sv
// In-order dispatch gate: grants the longest legal prefix of the decoded bundle
// and allocates store/load queue indices, owning the SQ/LQ head and tail pointers.
module dispatch_alloc_unit #(
  parameter int unsigned N_WAY  = 3,
  parameter int unsigned N_SQ   = 8,
  parameter int unsigned N_LQ   = 8,
  parameter int unsigned MAX_BR = 1,
  parameter int unsigned CNT_W  = 6,
  localparam int unsigned NUM_W = $clog2(N_WAY) + 1,
  localparam int unsigned SQ_IW = $clog2(N_SQ),
  localparam int unsigned SQ_PW = SQ_IW + 1,
  localparam int unsigned LQ_IW = $clog2(N_LQ),
  localparam int unsigned LQ_PW = LQ_IW + 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_WAY-1:0]         in_valid,
  input  logic [N_WAY-1:0]         in_is_store,
  input  logic [N_WAY-1:0]         in_is_load,
  input  logic [N_WAY-1:0]         in_is_branch,
  input  logic [N_WAY-1:0]         in_has_dest,
  input  logic [CNT_W-1:0]         rob_free,
  input  logic [CNT_W-1:0]         rs_free,
  input  logic [CNT_W-1:0]         fl_free,
  input  logic [NUM_W-1:0]         sq_retire_num,
  input  logic [NUM_W-1:0]         lq_retire_num,
  input  logic                     squash,
  input  logic [SQ_PW-1:0]         sq_restore_tail,
  input  logic [LQ_PW-1:0]         lq_restore_tail,
  output logic [N_WAY-1:0]         disp_grant,
  output logic [NUM_W-1:0]         disp_num,
  output logic [N_WAY*SQ_PW-1:0]   sq_idx,
  output logic [N_WAY*LQ_PW-1:0]   lq_idx,
  output logic [SQ_PW-1:0]         sq_tail_out,
  output logic [LQ_PW-1:0]         lq_tail_out,
  output logic [SQ_PW-1:0]         sq_count,
  output logic [LQ_PW-1:0]         lq_count,
  output logic                     stall
);

  logic [SQ_PW-1:0] sq_head_q, sq_head_d, sq_tail_q, sq_tail_d;
  logic [LQ_PW-1:0] lq_head_q, lq_head_d, lq_tail_q, lq_tail_d;

  int unsigned n_slot, n_dest, n_st, n_ld, n_br, n_grant, k_st, k_ld;
  logic        stop, blocked, fits;

  assign sq_count    = sq_tail_q - sq_head_q;
  assign lq_count    = lq_tail_q - lq_head_q;
  assign sq_tail_out = sq_tail_q;
  assign lq_tail_out = lq_tail_q;

  // Prefix grant: running totals are checked against every budget; the first
  // failure (or reset/squash) blocks that slot and all later ones.
  always_comb begin
    disp_grant = '0;
    stall      = 1'b0;
    stop       = 1'b0;
    blocked    = 1'b0;
    fits       = 1'b0;
    n_slot     = 0;
    n_dest     = 0;
    n_st       = 0;
    n_ld       = 0;
    n_br       = 0;
    n_grant    = 0;
    for (int i = 0; i < N_WAY; i++) begin
      if (!stop) begin
        if (!in_valid[i]) begin
          stop = 1'b1;
        end else begin
          n_slot++;
          if (in_has_dest[i])  n_dest++;
          if (in_is_store[i])  n_st++;
          if (in_is_load[i])   n_ld++;
          if (in_is_branch[i]) n_br++;
          fits = (n_slot <= 32'(rob_free)) && (n_slot <= 32'(rs_free)) &&
                 (n_dest <= 32'(fl_free)) &&
                 (n_st <= 32'(N_SQ) - 32'(sq_count)) &&
                 (n_ld <= 32'(N_LQ) - 32'(lq_count)) &&
                 ((MAX_BR == 0) || (n_br <= MAX_BR));
          if (fits && !blocked && reset && !squash) begin
            disp_grant[i] = 1'b1;
            n_grant++;
          end else begin
            blocked = 1'b1;
            stall   = reset;
          end
        end
      end
    end
    disp_num = NUM_W'(n_grant);
  end

  // Queue index stamping and next pointer state.
  always_comb begin
    sq_idx = '0;
    lq_idx = '0;
    k_st   = 0;
    k_ld   = 0;
    for (int i = 0; i < N_WAY; i++) begin
      if (disp_grant[i] && in_is_store[i]) begin
        sq_idx[i*SQ_PW +: SQ_PW] = SQ_PW'(SQ_IW'(sq_tail_q[SQ_IW-1:0] + SQ_IW'(k_st))) + SQ_PW'(1);
        k_st++;
      end
      if (disp_grant[i] && in_is_load[i]) begin
        lq_idx[i*LQ_PW +: LQ_PW] = LQ_PW'(LQ_IW'(lq_tail_q[LQ_IW-1:0] + LQ_IW'(k_ld))) + LQ_PW'(1);
        k_ld++;
      end
    end
    sq_head_d = sq_head_q + SQ_PW'(sq_retire_num);
    lq_head_d = lq_head_q + LQ_PW'(lq_retire_num);
    sq_tail_d = squash ? sq_restore_tail : sq_tail_q + SQ_PW'(k_st);
    lq_tail_d = squash ? lq_restore_tail : lq_tail_q + LQ_PW'(k_ld);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sq_head_q <= '0;
      sq_tail_q <= '0;
      lq_head_q <= '0;
      lq_tail_q <= '0;
    end else begin
      sq_head_q <= sq_head_d;
      sq_tail_q <= sq_tail_d;
      lq_head_q <= lq_head_d;
      lq_tail_q <= lq_tail_d;
    end
  end

  // Illegal-input checks; the design does not attempt recovery.
  a_sq_retire: assert property (@(posedge clock) disable iff (!reset)
    32'(sq_retire_num) <= 32'(sq_count));
  a_lq_retire: assert property (@(posedge clock) disable iff (!reset)
    32'(lq_retire_num) <= 32'(lq_count));
  a_mem_type: assert property (@(posedge clock) disable iff (!reset)
    (in_valid & in_is_store & in_is_load) == '0);
  a_sq_restore: assert property (@(posedge clock) disable iff (!reset)
    squash |-> (SQ_PW'(sq_restore_tail - sq_head_q) <= sq_count));
  a_lq_restore: assert property (@(posedge clock) disable iff (!reset)
    squash |-> (LQ_PW'(lq_restore_tail - lq_head_q) <= lq_count));

endmodule

// File: tb/tb_dispatch_alloc_unit.sv
// Bench for dispatch_alloc_unit: directed scenarios plus randomized traffic
// checked against a queue-occupancy reference model.
module tb_dispatch_alloc_unit;
  localparam int unsigned N_WAY = 3, N_SQ = 8, N_LQ = 8, MAX_BR = 1, CNT_W = 6;

  logic        clock, reset;
  logic [2:0]  in_valid, in_is_store, in_is_load, in_is_branch, in_has_dest;
  logic [5:0]  rob_free, rs_free, fl_free;
  logic [2:0]  sq_retire_num, lq_retire_num;
  logic        squash;
  logic [3:0]  sq_restore_tail, lq_restore_tail;
  logic [2:0]  disp_grant, disp_num;
  logic [11:0] sq_idx, lq_idx;
  logic [3:0]  sq_tail_out, lq_tail_out, sq_count, lq_count;
  logic        stall;

  int checks = 0, failures = 0;
  int m_sqh, m_sqt, m_lqh, m_lqt;
  logic [2:0]  e_grant, e_num;
  logic        e_stall;
  logic [11:0] e_sq_idx, e_lq_idx;

  dispatch_alloc_unit #(.N_WAY(N_WAY), .N_SQ(N_SQ), .N_LQ(N_LQ), .MAX_BR(MAX_BR), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_is_store(in_is_store),
    .in_is_load(in_is_load), .in_is_branch(in_is_branch), .in_has_dest(in_has_dest),
    .rob_free(rob_free), .rs_free(rs_free), .fl_free(fl_free),
    .sq_retire_num(sq_retire_num), .lq_retire_num(lq_retire_num), .squash(squash),
    .sq_restore_tail(sq_restore_tail), .lq_restore_tail(lq_restore_tail),
    .disp_grant(disp_grant), .disp_num(disp_num), .sq_idx(sq_idx), .lq_idx(lq_idx),
    .sq_tail_out(sq_tail_out), .lq_tail_out(lq_tail_out), .sq_count(sq_count),
    .lq_count(lq_count), .stall(stall));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Largest bundle length L whose first L slots are all valid and fit every budget.
  function automatic void model_eval();
    int len, nd, ns, nl, nb, f, ks, kl;
    bit ok;
    len = 0;
    for (int l = 1; l <= N_WAY; l++) begin
      ok = 1; nd = 0; ns = 0; nl = 0; nb = 0;
      for (int j = 0; j < l; j++) begin
        if (!in_valid[j]) ok = 0;
        nd += int'(in_has_dest[j]); ns += int'(in_is_store[j]);
        nl += int'(in_is_load[j]);  nb += int'(in_is_branch[j]);
      end
      if (l > int'(rob_free) || l > int'(rs_free) || nd > int'(fl_free)) ok = 0;
      if (ns > N_SQ - (m_sqt - m_sqh) || nl > N_LQ - (m_lqt - m_lqh)) ok = 0;
      if (MAX_BR != 0 && nb > MAX_BR) ok = 0;
      if (ok && reset && !squash) len = l;
    end
    f = N_WAY;
    for (int j = N_WAY - 1; j >= 0; j--) if (!in_valid[j]) f = j;
    e_grant = 3'((1 << len) - 1);
    e_num   = 3'(len);
    e_stall = reset && (len < f);
    e_sq_idx = '0; e_lq_idx = '0; ks = 0; kl = 0;
    for (int j = 0; j < N_WAY; j++) begin
      if (e_grant[j] && in_is_store[j]) begin e_sq_idx[j*4 +: 4] = 4'(((m_sqt + ks) % N_SQ) + 1); ks++; end
      if (e_grant[j] && in_is_load[j])  begin e_lq_idx[j*4 +: 4] = 4'(((m_lqt + kl) % N_LQ) + 1); kl++; end
    end
  endfunction

  function automatic void model_commit();
    int ns, nl;
    model_eval();
    if (!reset) begin
      m_sqh = 0; m_sqt = 0; m_lqh = 0; m_lqt = 0;
    end else begin
      ns = 0; nl = 0;
      for (int j = 0; j < N_WAY; j++)
        if (e_grant[j]) begin ns += int'(in_is_store[j]); nl += int'(in_is_load[j]); end
      if (squash) begin
        m_sqt = m_sqh + ((int'(sq_restore_tail) - m_sqh) & (2*N_SQ - 1));
        m_lqt = m_lqh + ((int'(lq_restore_tail) - m_lqh) & (2*N_LQ - 1));
      end else begin
        m_sqt += ns; m_lqt += nl;
      end
      m_sqh += int'(sq_retire_num);
      m_lqh += int'(lq_retire_num);
    end
  endfunction

  task automatic tick();
    model_commit();
    @(posedge clock); #1;
  endtask

  task automatic set_in(input logic [2:0] v, st, ld, br, dst, input logic [2:0] sr, lr);
    in_valid = v; in_is_store = st; in_is_load = ld; in_is_branch = br; in_has_dest = dst;
    sq_retire_num = sr; lq_retire_num = lr;
    rob_free = 6'd8; rs_free = 6'd8; fl_free = 6'd8;
    squash = 1'b0; sq_restore_tail = '0; lq_restore_tail = '0;
  endtask

  task automatic cyc(input logic [2:0] v, st, ld, input logic [2:0] sr, lr);
    set_in(v, st, ld, 3'b0, 3'b0, sr, lr);
    tick();
  endtask

  task automatic test_reset();
    set_in(3'b111, 3'b0, 3'b0, 3'b0, 3'b0, 3'd0, 3'd0);
    #1;
    checks++; if (disp_grant !== 3'b000) begin failures++; $display("FAIL reset_grant got=%b exp=000", disp_grant); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++; if (sq_count !== 4'd0 || lq_count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d/%0d exp=0/0", sq_count, lq_count); end
    checks++; if (sq_tail_out !== 4'd0 || lq_tail_out !== 4'd0) begin failures++; $display("FAIL reset_tail got=%0d/%0d exp=0/0", sq_tail_out, lq_tail_out); end
    reset = 1'b1;
    #1;
    checks++; if (disp_grant !== 3'b111 || disp_num !== 3'd3) begin failures++; $display("FAIL basic_grant got=%b/%0d exp=111/3", disp_grant, disp_num); end
    checks++; if (sq_idx !== 12'h000 || lq_idx !== 12'h000) begin failures++; $display("FAIL basic_idx got=%h/%h exp=000/000", sq_idx, lq_idx); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL basic_stall got=%b exp=0", stall); end
    tick();
  endtask

  task automatic test_budget();
    set_in(3'b111, 3'b0, 3'b0, 3'b0, 3'b0, 3'd0, 3'd0);
    rob_free = 6'd2;
    #1;
    checks++; if (disp_grant !== 3'b011 || stall !== 1'b1) begin failures++; $display("FAIL rob_budget got=%b stall=%b exp=011 stall=1", disp_grant, stall); end
    rob_free = 6'd8; fl_free = 6'd0; in_has_dest = 3'b010;
    #1;
    checks++; if (disp_grant !== 3'b001 || disp_num !== 3'd1) begin failures++; $display("FAIL fl_budget got=%b/%0d exp=001/1", disp_grant, disp_num); end
    set_in(3'b101, 3'b0, 3'b0, 3'b0, 3'b0, 3'd0, 3'd0);
    #1;
    checks++; if (disp_grant !== 3'b001 || stall !== 1'b0) begin failures++; $display("FAIL hole_prefix got=%b stall=%b exp=001 stall=0", disp_grant, stall); end
    tick();
  endtask

  task automatic test_sq_wrap();
    cyc(3'b111, 3'b111, 3'b000, 3'd0, 3'd0);
    cyc(3'b111, 3'b111, 3'b000, 3'd3, 3'd0);
    cyc(3'b000, 3'b000, 3'b000, 3'd3, 3'd0);
    set_in(3'b111, 3'b101, 3'b0, 3'b0, 3'b0, 3'd0, 3'd0);
    #1;
    checks++; if (sq_idx !== 12'h807 || disp_grant !== 3'b111) begin failures++; $display("FAIL sq_idx_tail6 got=%h/%b exp=807/111", sq_idx, disp_grant); end
    tick();
    checks++; if (sq_tail_out !== 4'd8 || sq_count !== 4'd2) begin failures++; $display("FAIL sq_tail8 got=%0d cnt=%0d exp=8 cnt=2", sq_tail_out, sq_count); end
    set_in(3'b001, 3'b001, 3'b0, 3'b0, 3'b0, 3'd0, 3'd0);
    #1;
    checks++; if (sq_idx !== 12'h001) begin failures++; $display("FAIL sq_idx_wrap got=%h exp=001", sq_idx); end
    tick();
  endtask

  task automatic test_sq_full();
    cyc(3'b111, 3'b111, 3'b000, 3'd0, 3'd0);
    cyc(3'b001, 3'b001, 3'b000, 3'd0, 3'd0);
    checks++; if (sq_count !== 4'd7) begin failures++; $display("FAIL sq_fill got=%0d exp=7", sq_count); end
    set_in(3'b011, 3'b011, 3'b0, 3'b0, 3'b0, 3'd1, 3'd0);
    #1;
    checks++; if (disp_grant !== 3'b001 || stall !== 1'b1) begin failures++; $display("FAIL sq_space got=%b stall=%b exp=001 stall=1", disp_grant, stall); end
    checks++; if (sq_idx !== 12'h006) begin failures++; $display("FAIL sq_space_idx got=%h exp=006", sq_idx); end
    tick();
    checks++; if (sq_count !== 4'd7 || sq_tail_out !== 4'd14) begin failures++; $display("FAIL sq_retire_same got=%0d tail=%0d exp=7 tail=14", sq_count, sq_tail_out); end
    cyc(3'b000, 3'b000, 3'b000, 3'd3, 3'd0);
    cyc(3'b000, 3'b000, 3'b000, 3'd3, 3'd0);
    cyc(3'b000, 3'b000, 3'b000, 3'd1, 3'd0);
    checks++; if (sq_count !== 4'd0) begin failures++; $display("FAIL sq_drain got=%0d exp=0", sq_count); end
  endtask

  task automatic test_branch_squash();
    set_in(3'b111, 3'b0, 3'b0, 3'b011, 3'b0, 3'd0, 3'd0);
    #1;
    checks++; if (disp_grant !== 3'b001 || stall !== 1'b1) begin failures++; $display("FAIL max_br got=%b stall=%b exp=001 stall=1", disp_grant, stall); end
    tick();
    cyc(3'b111, 3'b111, 3'b000, 3'd0, 3'd0);
    cyc(3'b000, 3'b000, 3'b000, 3'd3, 3'd0);
    cyc(3'b011, 3'b011, 3'b000, 3'd0, 3'd0);
    cyc(3'b011, 3'b011, 3'b000, 3'd0, 3'd0);
    checks++; if (sq_count !== 4'd4 || sq_tail_out !== 4'd5) begin failures++; $display("FAIL pre_squash got=%0d tail=%0d exp=4 tail=5", sq_count, sq_tail_out); end
    set_in(3'b111, 3'b001, 3'b0, 3'b0, 3'b0, 3'd1, 3'd0);
    squash = 1'b1; sq_restore_tail = 4'd3; lq_restore_tail = lq_tail_out;
    #1;
    checks++; if (disp_grant !== 3'b000 || disp_num !== 3'd0 || stall !== 1'b1) begin failures++; $display("FAIL squash_grant got=%b/%0d stall=%b exp=000/0 stall=1", disp_grant, disp_num, stall); end
    tick();
    checks++; if (sq_count !== 4'd1 || sq_tail_out !== 4'd3) begin failures++; $display("FAIL squash_restore got=%0d tail=%0d exp=1 tail=3", sq_count, sq_tail_out); end
  endtask

  task automatic test_reset_mid();
    cyc(3'b111, 3'b111, 3'b000, 3'd0, 3'd0);
    cyc(3'b001, 3'b001, 3'b000, 3'd0, 3'd0);
    set_in(3'b111, 3'b0, 3'b0, 3'b0, 3'b0, 3'd0, 3'd0);
    #1;
    checks++; if (sq_count !== 4'd5 || disp_grant !== 3'b111) begin failures++; $display("FAIL pre_reset got=%0d/%b exp=5/111", sq_count, disp_grant); end
    reset = 1'b0;
    m_sqh = 0; m_sqt = 0; m_lqh = 0; m_lqt = 0;
    #1;
    checks++; if (sq_count !== 4'd0 || sq_tail_out !== 4'd0 || disp_grant !== 3'b000) begin failures++; $display("FAIL async_reset got=%0d tail=%0d grant=%b exp=0 tail=0 grant=000", sq_count, sq_tail_out, disp_grant); end
    #1;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_random();
    int r, cs, cl, rs, rl, mx;
    for (int n = 0; n < 400; n++) begin
      for (int j = 0; j < N_WAY; j++) begin
        r = int'($urandom_range(0, 3));
        in_valid[j]     = ($urandom_range(0, 4) != 0);
        in_is_store[j]  = (r == 1);
        in_is_load[j]   = (r == 2);
        in_is_branch[j] = ($urandom_range(0, 3) == 0);
        in_has_dest[j]  = 1'($urandom_range(0, 1));
      end
      rob_free = ($urandom_range(0, 7) == 0) ? 6'd63 : 6'($urandom_range(0, 4));
      rs_free  = 6'($urandom_range(1, 9));
      fl_free  = 6'($urandom_range(0, 4));
      cs = m_sqt - m_sqh; cl = m_lqt - m_lqh;
      mx = (cs < 3) ? cs : 3; rs = int'($urandom_range(0, mx));
      mx = (cl < 3) ? cl : 3; rl = int'($urandom_range(0, mx));
      sq_retire_num = 3'(rs); lq_retire_num = 3'(rl);
      squash = ($urandom_range(0, 15) == 0);
      sq_restore_tail = 4'((m_sqh + int'($urandom_range(rs, cs))) % (2*N_SQ));
      lq_restore_tail = 4'((m_lqh + int'($urandom_range(rl, cl))) % (2*N_LQ));
      #1;
      model_eval();
      checks++; if (disp_grant !== e_grant) begin failures++; $display("FAIL rnd_grant n=%0d got=%b exp=%b", n, disp_grant, e_grant); end
      checks++; if (disp_num !== e_num) begin failures++; $display("FAIL rnd_num n=%0d got=%0d exp=%0d", n, disp_num, e_num); end
      checks++; if (stall !== e_stall) begin failures++; $display("FAIL rnd_stall n=%0d got=%b exp=%b", n, stall, e_stall); end
      checks++; if (sq_idx !== e_sq_idx) begin failures++; $display("FAIL rnd_sq_idx n=%0d got=%h exp=%h", n, sq_idx, e_sq_idx); end
      checks++; if (lq_idx !== e_lq_idx) begin failures++; $display("FAIL rnd_lq_idx n=%0d got=%h exp=%h", n, lq_idx, e_lq_idx); end
      checks++; if (sq_count !== 4'(m_sqt - m_sqh) || sq_tail_out !== 4'(m_sqt % (2*N_SQ))) begin failures++; $display("FAIL rnd_sq_state n=%0d got=%0d/%0d exp=%0d/%0d", n, sq_count, sq_tail_out, m_sqt - m_sqh, m_sqt % (2*N_SQ)); end
      checks++; if (lq_count !== 4'(m_lqt - m_lqh) || lq_tail_out !== 4'(m_lqt % (2*N_LQ))) begin failures++; $display("FAIL rnd_lq_state n=%0d got=%0d/%0d exp=%0d/%0d", n, lq_count, lq_tail_out, m_lqt - m_lqh, m_lqt % (2*N_LQ)); end
      tick();
    end
  endtask

  initial begin
    m_sqh = 0; m_sqt = 0; m_lqh = 0; m_lqt = 0;
    reset = 1'b0;
    set_in(3'b0, 3'b0, 3'b0, 3'b0, 3'b0, 3'd0, 3'd0);
    #12;
    test_reset();
    test_budget();
    test_sq_wrap();
    test_sq_full();
    test_branch_squash();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
